// File: rtl/wb_bram_arb.sv
// Two-master Wishbone classic arbiter sharing one wb_bram slave (LM32 I-bus = m0, D-bus = m1).
// Optional burst limit: define WB_ARB_BURST_LIMIT_EN to revoke a grant after max_burst acks when the other master waits.
module wb_bram_arb #(
  parameter int max_burst = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   last_reg;
  logic   req0;
  logic   req1;
  logic   limit_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_ARB_BURST_LIMIT_EN
  localparam logic [8:0] burst_lim = 9'(max_burst);

  logic [7:0] acnt_reg;
  logic [8:0] acnt_inc;

  assign acnt_inc  = {1'b0, acnt_reg} + 9'd1;
  assign limit_hit = s_ack_i && (acnt_inc >= burst_lim);

  // Acks counted per grant; IDLE always separates grants, so clearing there restarts the count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acnt_reg <= 8'd0;
    end else if (state_reg == IDLE) begin
      acnt_reg <= 8'd0;
    end else if (s_ack_i && (acnt_reg != 8'hff)) begin
      acnt_reg <= acnt_reg + 8'd1;
    end
  end
`else
  // Limit disabled: max_burst only feeds a constant-false term so the parameter stays referenced.
  localparam logic burst_cfg_ok = (max_burst >= 1) && (max_burst <= 255);

  assign limit_hit = 1'b0 && burst_cfg_ok;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && state_next == GNT0) begin
        last_reg <= 1'b0;
      end else if (state_reg == IDLE && state_next == GNT1) begin
        last_reg <= 1'b1;
      end
    end
  end

  // Grants only ever return to IDLE, so every hand-over drops s_stb_o for at least one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req0 && req1) begin
          state_next = last_reg ? GNT0 : GNT1;
        end else if (req0) begin
          state_next = GNT0;
        end else if (req1) begin
          state_next = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || (limit_hit && req1)) begin
          state_next = IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || (limit_hit && req0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    case (state_reg)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
      end
      default: begin
      end
    endcase
  end

  assign gnt_o    = {state_reg == GNT1, state_reg == GNT0};
  // Gating with the grant keeps a stray ack during IDLE from reaching either master.
  assign m0_ack_o = s_ack_i & gnt_o[0] & m0_stb_i;
  assign m1_ack_o = s_ack_i & gnt_o[1] & m1_stb_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_bram_arb.sv
// Self-checking bench for wb_bram_arb with a behavioural wb_bram (ack on the second strobe cycle).
// Burst expectations follow WB_ARB_BURST_LIMIT_EN, applied to the bench and the design alike.
module tb_wb_bram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;

  logic        bram_ack;
  logic        force_ack;
  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  always #5 clk = ~clk;

  wb_bram_arb #(.max_burst(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
    .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  function automatic logic [31:0] pat(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  // BRAM model: ack toggles high on the second strobe cycle, cleared whenever strobe drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_ack <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (s_cyc && s_stb && !bram_ack) begin
      bram_ack <= 1'b1;
      s_rdat   <= mem[s_adr[9:2]];
      if (s_we)
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_wdat[8*b +: 8];
    end else begin
      bram_ack <= 1'b0;
    end
  end
  assign s_ack = bram_ack | force_ack;

  task automatic to_mid();
    @(negedge clk);
  endtask

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_set(input logic cyc, input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = 4'hF;
  endtask

  task automatic m1_set(input logic cyc, input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = 4'hF;
  endtask

  task automatic do_reset();
    m0_set(0, 0, 0, 0, 0);
    m1_set(0, 0, 0, 0, 0);
    force_ack = 1'b0;
    rst_n = 1'b0;
    to_edge();
    to_edge();
    to_mid();
    rst_n = 1'b1;
    to_edge();
    exp0.delete();
    exp1.delete();
  endtask

  task automatic test_reset();
    logic [72:0] sbus;
    m0_set(0, 0, 0, 0, 0);
    m1_set(0, 0, 0, 0, 0);
    force_ack = 1'b0;
    rst_n = 1'b0;
    to_mid();
    sbus = {s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel};
    total++; if (sbus !== 73'd0) begin bad++; $display("FAIL reset_sbus: got %h want 0", sbus); end
    total++; if ({gnt, m0_ack, m1_ack} !== 4'b0000) begin bad++; $display("FAIL reset_gnt_ack: got %b want 0000", {gnt, m0_ack, m1_ack}); end
    rst_n = 1'b1;
    to_edge();
    m1_set(1, 1, 0, 32'h14, 0);
    to_mid();
    to_edge();
    to_mid();
    total++; if ({gnt, s_stb} !== 3'b101) begin bad++; $display("FAIL reset_pre_gnt1: got %b want 101", {gnt, s_stb}); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({s_stb, gnt, m1_ack} !== 4'b0000) begin bad++; $display("FAIL reset_midxfer: got %b want 0000", {s_stb, gnt, m1_ack}); end
    m1_set(0, 0, 0, 0, 0);
    to_edge();
    to_mid();
    rst_n = 1'b1;
    to_edge();
    m0_set(1, 1, 0, 32'h10, 0);
    to_mid();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_after_n: got %b want 00", gnt); end
    to_edge();
    to_mid();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL reset_after_n1: got %b want 01", gnt); end
    to_edge();
    m0_set(0, 0, 0, 0, 0);
    to_edge();
    to_edge();
  endtask

  task automatic test_single();
    logic [31:0] e;
    m0_set(1, 1, 0, 32'h10, 0);
    exp0.push_back(32'hDEADBEEF);
    to_mid();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL single_n: got %b want 00", gnt); end
    to_edge();
    to_mid();
    total++; if ({gnt, s_stb, m0_ack} !== 4'b0110) begin bad++; $display("FAIL single_n1: got %b want 0110", {gnt, s_stb, m0_ack}); end
    total++; if (s_adr !== 32'h10) begin bad++; $display("FAIL single_adr: got %h want 10", s_adr); end
    to_edge();
    to_mid();
    total++; if (m0_ack !== 1'b1) begin bad++; $display("FAIL single_ack: got %b want 1", m0_ack); end
    if (exp0.size() == 0) begin
      total++; bad++; $display("FAIL single_sb: scoreboard empty");
    end else begin
      e = exp0.pop_front();
      total++; if (m0_rdat !== e) begin bad++; $display("FAIL single_data: got %h want %h", m0_rdat, e); end
    end
    to_edge();
    m0_set(0, 0, 0, 0, 0);
    to_mid();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_drop: got %b want 01", gnt); end
    to_edge();
    to_mid();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL single_idle: got %b want 00", gnt); end
    to_edge();
  endtask

  task automatic test_contention();
    logic [31:0] e;
    do_reset();
    m0_set(1, 1, 0, 32'h10, 0); exp0.push_back(32'hDEADBEEF);
    m1_set(1, 1, 0, 32'h14, 0); exp1.push_back(pat(5));
    to_mid();
    to_edge(); to_mid();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL cont_first: got %b want 01", gnt); end
    to_edge(); to_mid();
    total++; if ({m0_ack, m1_ack} !== 2'b10) begin bad++; $display("FAIL cont_ack0: got %b want 10", {m0_ack, m1_ack}); end
    e = exp0.pop_front();
    total++; if (m0_rdat !== e) begin bad++; $display("FAIL cont_data0: got %h want %h", m0_rdat, e); end
    to_edge();
    m0_set(0, 0, 0, 0, 0);
    to_edge();
    m0_set(1, 1, 0, 32'h18, 0); exp0.push_back(pat(6));
    to_mid();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL cont_idle1: got %b want 00", gnt); end
    to_edge(); to_mid();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL cont_rr_m1: got %b want 10", gnt); end
    to_edge(); to_mid();
    total++; if ({m0_ack, m1_ack} !== 2'b01) begin bad++; $display("FAIL cont_ack1: got %b want 01", {m0_ack, m1_ack}); end
    e = exp1.pop_front();
    total++; if (m1_rdat !== e) begin bad++; $display("FAIL cont_data1: got %h want %h", m1_rdat, e); end
    to_edge();
    m1_set(0, 0, 0, 0, 0);
    to_edge(); to_mid();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL cont_idle2: got %b want 00", gnt); end
    to_edge(); to_mid();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL cont_regrant0: got %b want 01", gnt); end
    to_edge(); to_mid();
    total++; if (m0_ack !== 1'b1) begin bad++; $display("FAIL cont_ack0b: got %b want 1", m0_ack); end
    e = exp0.pop_front();
    total++; if (m0_rdat !== e) begin bad++; $display("FAIL cont_data0b: got %h want %h", m0_rdat, e); end
    to_edge();
    m0_set(0, 0, 0, 0, 0);
    to_edge(); to_edge();
  endtask

  task automatic test_write_isolation();
    logic [31:0] e;
    int waited;
    m1_set(1, 1, 1, 32'h20, 32'h12345678);
    to_mid();
    to_edge();
    m0_set(1, 1, 0, 32'h20, 0); exp0.push_back(32'h12345678);
    to_mid();
    total++; if ({gnt, s_we, s_wdat} !== {2'b10, 1'b1, 32'h12345678}) begin bad++; $display("FAIL wr_mux: got %b %b %h want 10 1 12345678", gnt, s_we, s_wdat); end
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        total++; if (m1_ack !== 1'b1) begin bad++; $display("FAIL wr_ack1: got %b want 1", m1_ack); end
      end
      total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL wr_isolate_c%0d: got %b want 0", c, m0_ack); end
      to_edge();
      if (c == 1) m1_set(0, 0, 0, 0, 0);
      to_mid();
    end
    waited = 0;
    while (m0_ack !== 1'b1 && waited < 20) begin
      to_edge(); to_mid();
      waited++;
    end
    total++;
    if (waited >= 20) begin
      bad++; $display("FAIL wr_readback_timeout: got no ack want ack");
    end else begin
      e = exp0.pop_front();
      if (m0_rdat !== e) begin bad++; $display("FAIL wr_readback: got %h want %h", m0_rdat, e); end
    end
    to_edge();
    m0_set(0, 0, 0, 0, 0);
    to_edge(); to_edge();
  endtask

  task automatic test_burst();
    logic [31:0] e;
    int n0 = 0, n1 = 0, g1_at = -1, c4 = -1, cyc = 0;
    bit m1_started = 0, done = 0, d0, d1;
`ifdef WB_ARB_BURST_LIMIT_EN
    int want_g1 = 4;
    logic [1:0] want_c4a = 2'b00, want_c4b = 2'b10;
`else
    int want_g1 = 10;
    logic [1:0] want_c4a = 2'b01, want_c4b = 2'b01;
`endif
    m0_set(1, 1, 0, 32'h100, 0); exp0.push_back(pat(64));
    while (!done && cyc < 300) begin
      to_mid();
      if (gnt === 2'b10 && g1_at < 0) g1_at = n0;
      if (c4 >= 0 && cyc == c4 + 1) begin
        total++; if (gnt !== want_c4a) begin bad++; $display("FAIL burst_after4_a: got %b want %b", gnt, want_c4a); end
      end
      if (c4 >= 0 && cyc == c4 + 2) begin
        total++; if (gnt !== want_c4b) begin bad++; $display("FAIL burst_after4_b: got %b want %b", gnt, want_c4b); end
      end
      d0 = m0_ack; d1 = m1_ack;
      if (d0) begin
        n0++;
        if (n0 == 4) c4 = cyc;
        e = (exp0.size() != 0) ? exp0.pop_front() : 32'hxxxxxxxx;
        total++; if (m0_rdat !== e) begin bad++; $display("FAIL burst_data0_%0d: got %h want %h", n0, m0_rdat, e); end
      end
      if (d1) begin
        n1++;
        e = (exp1.size() != 0) ? exp1.pop_front() : 32'hxxxxxxxx;
        total++; if (m1_rdat !== e) begin bad++; $display("FAIL burst_data1: got %h want %h", m1_rdat, e); end
      end
      if (n0 == 10 && n1 == 1 && gnt === 2'b00 && !m0_cyc && !m1_cyc) done = 1;
      to_edge();
      if (cyc == 1 && !m1_started) begin
        m1_set(1, 1, 0, 32'h200, 0); exp1.push_back(pat(128));
        m1_started = 1;
      end
      if (d0) begin
        if (n0 == 10) m0_set(0, 0, 0, 0, 0);
        else begin
          m0_set(1, 1, 0, 32'h100 + 32'(4 * n0), 0); exp0.push_back(pat(64 + n0));
        end
      end
      if (d1) m1_set(0, 0, 0, 0, 0);
      cyc++;
    end
    total++; if (!done) begin bad++; $display("FAIL burst_timeout: got n0=%0d n1=%0d want 10 1", n0, n1); end
    total++; if (g1_at != want_g1) begin bad++; $display("FAIL burst_acks_before_gnt1: got %0d want %0d", g1_at, want_g1); end
    m0_set(0, 0, 0, 0, 0);
    m1_set(0, 0, 0, 0, 0);
    to_edge();
  endtask

  task automatic test_stray_ack();
    m0_set(0, 1, 0, 32'h10, 0);
    m1_set(0, 1, 0, 32'h14, 0);
    force_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      to_mid();
      total++; if ({gnt, s_stb, m0_ack, m1_ack} !== 5'b00000) begin bad++; $display("FAIL stray_ack_c%0d: got %b want 00000", c, {gnt, s_stb, m0_ack, m1_ack}); end
      to_edge();
    end
    force_ack = 1'b0;
    m0_set(0, 0, 0, 0, 0);
    m1_set(0, 0, 0, 0, 0);
    to_edge();
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_write_isolation();
    test_burst();
    test_stray_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
